// File: rtl/uart_bus_arbiter_pkg.sv
// Shared widths, state encodings and watchdog helpers for the UART bus arbiter.
// Mirrors the femto.vh bus defines so the arbiter elaborates without the header.
package uart_bus_arbiter_pkg;

    localparam int FEMTO_XLEN        = 32;
    localparam int FEMTO_BUS_WIDTH   = 32;
    localparam int FEMTO_BUS_ACC_CNT = 4;
    localparam int UART_BUS_TIMEOUT  = 255;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    typedef logic [9:0] cnt_t;

    // Watchdog counter stops at all-ones instead of wrapping back to zero.
    function automatic cnt_t cnt_sat_inc(input cnt_t c);
        return (c == '1) ? c : c + cnt_t'(1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the master that did not win last time is chosen.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_idx   = 1'b0;
        if (req0 && req1) begin
            grant_idx = ~last_grant;
        end else if (req1) begin
            grant_idx = 1'b1;
        end
    end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Shares the UART wrapper's single bus slave port between the CPU (m0) and DMA/boot (m1),
// one outstanding transfer at a time, with a watchdog that aborts a hung slave.
//
// state    | meaning
// ARB_IDLE | no grant; pick a requester and latch its fields
// ARB_BUSY | s_req held; wait for s_resp or watchdog expiry
module uart_bus_arbiter
    import uart_bus_arbiter_pkg::*;
#(
    parameter int XLEN      = FEMTO_XLEN,
    parameter int BUS_WIDTH = FEMTO_BUS_WIDTH,
    parameter int ACC_W     = $clog2(FEMTO_BUS_ACC_CNT),
    parameter int TIMEOUT   = UART_BUS_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic [XLEN-1:0]      m0_addr,
    input  logic                 m0_w_rb,
    input  logic [ACC_W-1:0]     m0_acc,
    input  logic [BUS_WIDTH-1:0] m0_wdata,
    input  logic                 m0_req,
    output logic [BUS_WIDTH-1:0] m0_rdata,
    output logic                 m0_resp,
    output logic                 m0_fault,

    input  logic [XLEN-1:0]      m1_addr,
    input  logic                 m1_w_rb,
    input  logic [ACC_W-1:0]     m1_acc,
    input  logic [BUS_WIDTH-1:0] m1_wdata,
    input  logic                 m1_req,
    output logic [BUS_WIDTH-1:0] m1_rdata,
    output logic                 m1_resp,
    output logic                 m1_fault,

    output logic [XLEN-1:0]      s_addr,
    output logic                 s_w_rb,
    output logic [ACC_W-1:0]     s_acc,
    output logic [BUS_WIDTH-1:0] s_wdata,
    output logic                 s_req,
    input  logic [BUS_WIDTH-1:0] s_rdata,
    input  logic                 s_resp,
    input  logic                 s_fault
);

    localparam cnt_t TIMEOUT_CNT = cnt_t'(TIMEOUT);

    logic [0:0]           state;
    logic                 owner;
    logic                 last_grant;
    cnt_t                 cnt;
    logic                 grant_valid;
    logic                 grant_idx;
    logic                 done;
    logic [BUS_WIDTH-1:0] rsp_rdata;
    logic                 rsp_fault;

    rr_arb2 u_rr_arb2 (
        .req0        (m0_req),
        .req1        (m1_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // A real slave response takes priority over a watchdog expiry in the same cycle.
    assign done      = (state == ARB_BUSY) && (s_resp || (cnt == TIMEOUT_CNT));
    assign rsp_rdata = s_resp ? s_rdata : '0;
    assign rsp_fault = s_resp ? s_fault : 1'b1;
    assign s_req     = (state == ARB_BUSY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ARB_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            s_addr     <= '0;
            s_w_rb     <= 1'b0;
            s_acc      <= '0;
            s_wdata    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        state      <= ARB_BUSY;
                        owner      <= grant_idx;
                        last_grant <= grant_idx;
                        cnt        <= '0;
                        s_addr     <= grant_idx ? m1_addr  : m0_addr;
                        s_w_rb     <= grant_idx ? m1_w_rb  : m0_w_rb;
                        s_acc      <= grant_idx ? m1_acc   : m0_acc;
                        s_wdata    <= grant_idx ? m1_wdata : m0_wdata;
                    end
                end
                ARB_BUSY: begin
                    if (done) begin
                        state <= ARB_IDLE;
                    end else begin
                        cnt <= cnt_sat_inc(cnt);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    always_comb begin
        m0_resp  = 1'b0;
        m0_fault = 1'b0;
        m0_rdata = '0;
        m1_resp  = 1'b0;
        m1_fault = 1'b0;
        m1_rdata = '0;
        if (done) begin
            if (owner) begin
                m1_resp  = 1'b1;
                m1_fault = rsp_fault;
                m1_rdata = rsp_rdata;
            end else begin
                m0_resp  = 1'b1;
                m0_fault = rsp_fault;
                m0_rdata = rsp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Directed bench for uart_bus_arbiter: stimulus pushes expected responses into a
// scoreboard queue and a negedge monitor pops and compares every response pulse.
module tb_uart_bus_arbiter;

    localparam int XLEN      = 32;
    localparam int BUS_WIDTH = 32;
    localparam int ACC_W     = 2;
    localparam int TIMEOUT   = 4;

    logic                 clk;
    logic                 rst;
    logic [XLEN-1:0]      m0_addr,  m1_addr;
    logic                 m0_w_rb,  m1_w_rb;
    logic [ACC_W-1:0]     m0_acc,   m1_acc;
    logic [BUS_WIDTH-1:0] m0_wdata, m1_wdata;
    logic                 m0_req,   m1_req;
    logic [BUS_WIDTH-1:0] m0_rdata, m1_rdata;
    logic                 m0_resp,  m1_resp;
    logic                 m0_fault, m1_fault;
    logic [XLEN-1:0]      s_addr;
    logic                 s_w_rb;
    logic [ACC_W-1:0]     s_acc;
    logic [BUS_WIDTH-1:0] s_wdata;
    logic                 s_req;
    logic [BUS_WIDTH-1:0] s_rdata;
    logic                 s_resp;
    logic                 s_fault;

    typedef struct packed {
        logic                 idx;
        logic [BUS_WIDTH-1:0] rdata;
        logic                 fault;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    uart_bus_arbiter #(
        .XLEN      (XLEN),
        .BUS_WIDTH (BUS_WIDTH),
        .ACC_W     (ACC_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_addr  (m0_addr),
        .m0_w_rb  (m0_w_rb),
        .m0_acc   (m0_acc),
        .m0_wdata (m0_wdata),
        .m0_req   (m0_req),
        .m0_rdata (m0_rdata),
        .m0_resp  (m0_resp),
        .m0_fault (m0_fault),
        .m1_addr  (m1_addr),
        .m1_w_rb  (m1_w_rb),
        .m1_acc   (m1_acc),
        .m1_wdata (m1_wdata),
        .m1_req   (m1_req),
        .m1_rdata (m1_rdata),
        .m1_resp  (m1_resp),
        .m1_fault (m1_fault),
        .s_addr   (s_addr),
        .s_w_rb   (s_w_rb),
        .s_acc    (s_acc),
        .s_wdata  (s_wdata),
        .s_req    (s_req),
        .s_rdata  (s_rdata),
        .s_resp   (s_resp),
        .s_fault  (s_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic idx, input logic [BUS_WIDTH-1:0] rd, input logic flt);
        exp_t e;
        e.idx   = idx;
        e.rdata = rd;
        e.fault = flt;
        sb.push_back(e);
    endtask

    task automatic wait_sreq(output int waited);
        waited = 0;
        while (!s_req && waited < 20) begin
            tick();
            waited++;
        end
        chk("wait_sreq", s_req, 1);
    endtask

    // Wait for the grant, check the latched address, answer after 'delay' BUSY cycles.
    task automatic serve(input logic [XLEN-1:0] exp_addr, input int delay,
                         input logic [BUS_WIDTH-1:0] rd, input logic flt, output int waited);
        wait_sreq(waited);
        chk("grant_addr", s_addr, exp_addr);
        repeat (delay) tick();
        s_resp  = 1'b1;
        s_rdata = rd;
        s_fault = flt;
        tick();
        s_resp  = 1'b0;
        s_rdata = '0;
        s_fault = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: every response pulse must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        logic                 gidx;
        logic [BUS_WIDTH-1:0] grd, ord;
        logic                 gflt, oflt;
        if (!rst && (m0_resp || m1_resp)) begin
            checks++;
            gidx = m1_resp;
            grd  = gidx ? m1_rdata : m0_rdata;
            gflt = gidx ? m1_fault : m0_fault;
            ord  = gidx ? m0_rdata : m1_rdata;
            oflt = gidx ? m0_fault : m1_fault;
            if (m0_resp && m1_resp) begin
                failures++;
                $display("FAIL dual_resp m0_resp=1 m1_resp=1 expected at most one");
            end else if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp m0_resp=%0b m1_resp=%0b expected none", m0_resp, m1_resp);
            end else begin
                e = sb.pop_front();
                if (gidx !== e.idx || grd !== e.rdata || gflt !== e.fault || ord !== '0 || oflt !== 1'b0) begin
                    failures++;
                    $display("FAIL sb_resp actual m%0d rdata=%0h fault=%0b other=%0h/%0b expected m%0d rdata=%0h fault=%0b other=0/0",
                             gidx, grd, gflt, ord, oflt, e.idx, e.rdata, e.fault);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        rst = 1'b1;
        m0_addr = '0; m0_w_rb = 1'b0; m0_acc = '0; m0_wdata = '0; m0_req = 1'b0;
        m1_addr = '0; m1_w_rb = 1'b0; m1_acc = '0; m1_wdata = '0; m1_req = 1'b0;
        s_rdata = '0; s_resp = 1'b0; s_fault = 1'b0;
        repeat (3) tick();
        chk("rst_s_req",   s_req,   0);
        chk("rst_s_addr",  s_addr,  0);
        chk("rst_s_wdata", s_wdata, 0);
        chk("rst_m_resp",  {m0_resp, m1_resp, m0_fault, m1_fault}, 0);
        rst = 1'b0;
        tick();

        // m0 read alone, slave answers 3 cycles after s_req
        m0_addr = 32'h10; m0_acc = 2'd2; m0_w_rb = 1'b0; m0_req = 1'b1;
        push_exp(1'b0, 32'hA5A5_0001, 1'b0);
        chk("t1_idle_s_req", s_req, 0);
        tick();
        chk("t1_s_req", s_req, 1);
        chk("t1_s_addr", s_addr, 32'h10);
        chk("t1_s_acc", s_acc, 2);
        chk("t1_s_w_rb", s_w_rb, 0);
        tick(); tick();
        chk("t1_early_resp", m0_resp, 0);
        tick();
        s_resp = 1'b1; s_rdata = 32'hA5A5_0001;
        #1;
        chk("t1_m0_resp", m0_resp, 1);
        chk("t1_m0_rdata", m0_rdata, 32'hA5A5_0001);
        chk("t1_m1_resp", m1_resp, 0);
        tick();
        s_resp = 1'b0; s_rdata = '0; m0_req = 1'b0;
        chk("t1_s_req_drop", s_req, 0);
        tick();

        // tie alternation after reset, 8 transfers
        do_reset();
        m0_addr = 32'h100; m1_addr = 32'h200;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_exp(1'(i % 2), 32'h1000 + i, 1'b0);
            serve((i % 2 == 1) ? 32'h200 : 32'h100, i % 3, 32'h1000 + i, 1'b0, w);
            chk("rr_grant_latency", w, 1);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();

        // slave never answers: watchdog abort on the cnt==TIMEOUT cycle
        m0_addr = 32'h40; m0_req = 1'b1;
        s_rdata = 32'h1234_5678;
        push_exp(1'b0, 32'h0, 1'b1);
        wait_sreq(w);
        repeat (TIMEOUT - 1) tick();
        chk("to_early_resp", m0_resp, 0);
        tick();
        chk("to_m0_resp", m0_resp, 1);
        chk("to_m0_fault", m0_fault, 1);
        chk("to_m0_rdata", m0_rdata, 0);
        tick();
        m0_req = 1'b0; s_rdata = '0;
        chk("to_s_req_drop", s_req, 0);
        tick();

        // slave response coinciding with watchdog expiry wins
        m1_addr = 32'h80; m1_req = 1'b1;
        push_exp(1'b1, 32'hDEAD_BEEF, 1'b1);
        wait_sreq(w);
        repeat (TIMEOUT) tick();
        s_resp = 1'b1; s_fault = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #1;
        chk("race_m1_resp", m1_resp, 1);
        chk("race_m1_rdata", m1_rdata, 32'hDEAD_BEEF);
        tick();
        s_resp = 1'b0; s_fault = 1'b0; s_rdata = '0; m1_req = 1'b0;
        chk("race_s_req_drop", s_req, 0);
        chk("race_single_pulse", m1_resp, 0);
        tick();

        // reset while m1 owns the bus
        m1_addr = 32'h300; m1_req = 1'b1;
        wait_sreq(w);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_s_req", s_req, 0);
        chk("rst_mid_m1_resp", m1_resp, 0);
        m1_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        m0_addr = 32'h500; m1_addr = 32'h600;
        m0_req = 1'b1; m1_req = 1'b1;
        push_exp(1'b0, 32'h55, 1'b0);
        serve(32'h500, 1, 32'h55, 1'b0, w);
        m0_req = 1'b0;
        push_exp(1'b1, 32'h66, 1'b0);
        serve(32'h600, 0, 32'h66, 1'b0, w);
        m1_req = 1'b0;
        tick();

        // stray slave response while idle
        s_resp = 1'b1; s_rdata = 32'hFFFF;
        #1;
        chk("stray_resp", {m0_resp, m1_resp}, 0);
        tick();
        s_resp = 1'b0; s_rdata = '0;
        tick();

        // m1 fields change while it waits behind m0; grant takes the final values
        m0_addr = 32'h400; m0_req = 1'b1;
        push_exp(1'b0, 32'h77, 1'b0);
        wait_sreq(w);
        m1_req = 1'b1; m1_addr = 32'h500; m1_w_rb = 1'b0; m1_acc = 2'd0; m1_wdata = 32'h1;
        tick();
        m1_addr = 32'h504; m1_w_rb = 1'b1; m1_acc = 2'd1; m1_wdata = 32'hCAFE_F00D;
        tick();
        s_resp = 1'b1; s_rdata = 32'h77;
        tick();
        s_resp = 1'b0; s_rdata = '0; m0_req = 1'b0;
        push_exp(1'b1, 32'h0, 1'b0);
        wait_sreq(w);
        chk("late_m1_wait", w, 1);
        chk("late_m1_addr", s_addr, 32'h504);
        chk("late_m1_w_rb", s_w_rb, 1);
        chk("late_m1_acc", s_acc, 1);
        chk("late_m1_wdata", s_wdata, 32'hCAFE_F00D);
        s_resp = 1'b1;
        tick();
        s_resp = 1'b0; m1_req = 1'b0;
        repeat (3) tick();

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
